// File: rtl/axis_frame_fifo_if.sv
// Stream-side signal bundle of axis_frame_fifo: input beat channel and output beat channel.
interface axis_frame_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   dataIn;
  logic                    dataInTValid;
  logic                    dataInTReady;
  logic                    dataInTLast;
  logic [DATA_WIDTH/8-1:0] dataInTStrb;
  logic [DATA_WIDTH-1:0]   dataOut;
  logic                    dataOutTValid;
  logic                    dataOutTReady;
  logic                    dataOutTLast;
  logic [DATA_WIDTH/8-1:0] dataOutTStrb;

  // FIFO side
  modport slave (
    input  dataIn, dataInTValid, dataInTLast, dataInTStrb, dataOutTReady,
    output dataInTReady, dataOut, dataOutTValid, dataOutTLast, dataOutTStrb
  );

  // Producer/consumer side
  modport master (
    output dataIn, dataInTValid, dataInTLast, dataInTStrb, dataOutTReady,
    input  dataInTReady, dataOut, dataOutTValid, dataOutTLast, dataOutTStrb
  );
endinterface

// File: rtl/axis_frame_fifo.sv
// Single-clock AXI-Stream frame FIFO with registered output stage, optional
// store-and-forward mode and frame accounting.
module axis_frame_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter bit          PACKET_MODE = 1'b0,
  parameter int unsigned PW          = $clog2(DEPTH) + 1
) (
  input  logic                  streamClock,
  input  logic                  streamResetN,
  axis_frame_fifo_if.slave      bus,
  output logic [PW-1:0]         occupancy,
  output logic [PW-1:0]         frameCount,
  output logic [15:0]           lastFrameLength,
  output logic                  frameOverrun,
  input  logic                  clearStatus
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned MW = DATA_WIDTH + SW + 1;
  localparam int unsigned AW = PW - 1;

  logic [MW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW-1:0]         frameCount_q, frameCount_d, occ_d;
  logic                  ready_q, outValid_q, outLast_q;
  logic [DATA_WIDTH-1:0] outData_q;
  logic [SW-1:0]         outStrb_q;
  logic [15:0]           beatCnt_q, lastLen_q;
  logic                  overrun_q, cutThru_q;
  logic                  accept, empty, permit, xfer, load, loadLast, ctSet;
  logic [MW-1:0]         rdWord;

  assign occupancy = wrPtr_q - rdPtr_q;

  always_comb begin
    accept   = bus.dataInTValid && ready_q;
    empty    = (wrPtr_q == rdPtr_q);
    permit   = !PACKET_MODE || (frameCount_q != '0) || cutThru_q;
    xfer     = outValid_q && bus.dataOutTReady;
    load     = !empty && permit && (!outValid_q || bus.dataOutTReady);
    rdWord   = mem_q[rdPtr_q[AW-1:0]];
    loadLast = load && rdWord[MW-1];
    // A full RAM with no complete frame can never satisfy store-and-forward.
    ctSet    = PACKET_MODE && (occupancy == PW'(DEPTH)) && (frameCount_q == '0);
    wrPtr_d  = wrPtr_q + PW'(accept);
    rdPtr_d  = rdPtr_q + PW'(load);
    occ_d    = wrPtr_d - rdPtr_d;
    frameCount_d = frameCount_q + PW'(accept && bus.dataInTLast) - PW'(loadLast);
  end

  always_ff @(posedge streamClock) begin
    if (accept) mem_q[wrPtr_q[AW-1:0]] <= {bus.dataInTLast, bus.dataInTStrb, bus.dataIn};
  end

  always_ff @(posedge streamClock) begin
    if (!streamResetN) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      frameCount_q <= '0;
      ready_q      <= 1'b0;
      outValid_q   <= 1'b0;
      outLast_q    <= 1'b0;
      outStrb_q    <= '0;
      outData_q    <= '0;
      beatCnt_q    <= '0;
      lastLen_q    <= '0;
      overrun_q    <= 1'b0;
      cutThru_q    <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      frameCount_q <= frameCount_d;
      ready_q      <= (occ_d != PW'(DEPTH));

      if (load) begin
        outValid_q <= 1'b1;
        {outLast_q, outStrb_q, outData_q} <= rdWord;
      end else if (xfer) begin
        outValid_q <= 1'b0;
      end

      if (xfer) begin
        if (outLast_q) begin
          lastLen_q <= (beatCnt_q == 16'hFFFF) ? 16'hFFFF : beatCnt_q + 16'd1;
          beatCnt_q <= '0;
        end else if (beatCnt_q != 16'hFFFF) begin
          beatCnt_q <= beatCnt_q + 16'd1;
        end
      end

      if (ctSet)         cutThru_q <= 1'b1;
      else if (loadLast) cutThru_q <= 1'b0;

      if (ctSet)            overrun_q <= 1'b1;
      else if (clearStatus) overrun_q <= 1'b0;
    end
  end

  assign bus.dataInTReady  = ready_q;
  assign bus.dataOut       = outData_q;
  assign bus.dataOutTValid = outValid_q;
  assign bus.dataOutTLast  = outLast_q;
  assign bus.dataOutTStrb  = outStrb_q;
  assign frameCount        = frameCount_q;
  assign lastFrameLength   = lastLen_q;
  assign frameOverrun      = overrun_q;
endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Parametrised single-clock AXI-Stream frame FIFO for the frame coprocessor datapath. It sits between the DMA input stream and the processing engines. Over the first-generation buffer it adds:
- configurable data width and depth;
- true full/empty detection using an extra pointer bit;
- TSTRB storage alongside data;
- an optional store-and-forward (packet) mode;
- frame accounting and status outputs.

## Interface
- DATA_WIDTH, 32, data bits per beat; multiple of 8.
- DEPTH, 32, RAM entries; power of two, >= 4.
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward (output starts only once a whole frame is buffered).
- PW, $clog2(DEPTH)+1, derived width for counts and pointers.

- streamClock  in  1  sole clock; all logic on its rising edge.
- streamResetN  in  1  synchronous, active-low reset.
- dataIn  in  DATA_WIDTH  input beat data.
- dataInTValid  in  1  input beat valid.
- dataInTReady  out  1  input ready (registered).
- dataInTLast  in  1  last beat of frame.
- dataInTStrb  in  DATA_WIDTH/8  byte strobes, stored with the beat.
- dataOut  out  DATA_WIDTH  output beat data (registered).
- dataOutTValid  out  1  output valid (registered).
- dataOutTReady  in  1  downstream ready.
- dataOutTLast  out  1  last beat of frame.
- dataOutTStrb  out  DATA_WIDTH/8  stored strobes.
- occupancy  out  PW  beats held in RAM (0..DEPTH); excludes the output register.
- frameCount  out  PW  TLast beats held in RAM.
- lastFrameLength  out  16  beats in the most recent frame fully transferred out; saturates at 16'hFFFF.
- frameOverrun  out  1  sticky; set when packet mode is forced into cut-through.
- clearStatus  in  1  synchronous clear of frameOverrun.

## Operation
- **Storage.** RAM of DEPTH x (DATA_WIDTH + DATA_WIDTH/8 + 1) holds {last, strb, data}.
- **Pointers.** wrPtr and rdPtr are PW bits wide.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
  - Wrap-around is natural modulo 2*DEPTH.
- **Input.** A beat is accepted when dataInTValid && dataInTReady.
  - On acceptance: write to RAM[wrPtr], then increment wrPtr.
  - dataInTReady is registered as (next occupancy != DEPTH).
- **Output register.**
  - Load condition: RAM is non-empty, load is permitted, and either dataOutTValid == 0 or (dataOutTValid && dataOutTReady).
  - Load action: take RAM[rdPtr], increment rdPtr, set dataOutTValid = 1.
  - If the register is consumed and no load occurs, dataOutTValid drops to 0.
  - dataOut, dataOutTStrb and dataOutTLast stay stable while dataOutTValid && !dataOutTReady.
- **Load permission.**
  - PACKET_MODE = 0: always permitted.
  - PACKET_MODE = 1: permitted if frameCount > 0, or the cut-through latch is set.
- **Cut-through latch (packet mode only).**
  - Set when occupancy == DEPTH and frameCount == 0; frameOverrun is set in the same cycle.
  - Cleared when a TLast beat is loaded into the output register.
  - Purpose: prevents deadlock on frames longer than DEPTH.
- **frameCount.**
  - +1 on an accepted TLast beat.
  - -1 on loading a TLast beat into the output register.
  - Both in one cycle: unchanged.
- **occupancy.**
  - +1 on accept, -1 on load; both in one cycle: unchanged.
- **Frame length.**
  - A beat counter increments on each output transfer.
  - On a transfer with TLast: lastFrameLength <= counter + 1 (saturating), then the counter resets to 0.
- **frameOverrun.** Set-priority over clearStatus when both occur in the same cycle.

## Timing
- Reset (streamResetN == 0 at an edge) produces:
  - pointers, occupancy, frameCount, beat counter and cut-through latch = 0;
  - dataInTReady = 0, dataOutTValid = 0, dataOutTLast = 0, dataOutTStrb = 0, dataOut = 0;
  - lastFrameLength = 0, frameOverrun = 0.
- RAM contents are not reset. A reset mid-frame discards all buffered beats, with no partial output afterwards.
- First edge after reset release: dataInTReady = 1.
- Cut-through latency:
  - A beat accepted at edge k into an empty FIFO with an empty output register loads at edge k+1.
  - dataOutTValid is high from edge k+1.
- Packet-mode latency: the first beat of a frame loads at the edge after its TLast beat is accepted.
- Full: the cycle after the DEPTH-th stored beat, dataInTReady = 0. A simultaneous load re-asserts it the next cycle.
- Throughput: one beat per cycle sustained in both directions once primed.

## Test plan
1. **Reset defaults.** Reset for 3 cycles -> all outputs zero. dataInTReady = 1 one edge after release.
2. **Cut-through, DEPTH = 4.** Stream 8 beats 0x1..0x8, last on 0x4 and 0x8, with dataOutTReady = 1.
   - Output order is 0x1..0x8 with TLast on 0x4 and 0x8.
   - First valid one cycle after the first accept.
   - lastFrameLength = 4.
3. **Full/backpressure.** dataOutTReady = 0, push 6 beats into DEPTH = 4.
   - 5 beats are taken (4 in RAM + 1 in the output register); occupancy = 4; dataInTReady = 0.
   - Release ready -> all 5 beats come out in order, then the 6th.
4. **Packet mode.** Send a 3-beat frame with a 2-cycle gap before TLast.
   - dataOutTValid stays 0 until the edge after the TLast accept, then 3 back-to-back beats.
   - frameCount goes 1 -> 0.
5. **Packet overrun, DEPTH = 4.** Send a 7-beat frame.
   - frameOverrun = 1 once occupancy reaches 4; the frame passes intact.
   - clearStatus -> frameOverrun = 0.
6. **Mid-frame reset.** Send 2 of 4 beats, assert reset 1 cycle, then send a 1-beat frame 0xAA.
   - The only output is 0xAA with TLast; lastFrameLength = 1.
